// File: rtl/matricula_sym_tx.sv
// matricula_sym_tx: sends a word as 2-bit symbols, MSB first, after a one-cycle active-low reset pulse to the downstream FSM.
// Define MATRICULA_SYM_TX_LOOP_EN to replay the latched word until abort or reset.
module matricula_sym_tx #(
    parameter int WIDTH = 17,
    parameter int HOLD  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             abort,
    output logic [1:0]       a,
    output logic             a_valid,
    output logic             fsm_res,
    output logic             busy,
    output logic             done
);
    localparam int NSYM = (WIDTH + 1) / 2;
    localparam int KW = $clog2(NSYM + 1);
    localparam int HW = $clog2(HOLD + 1);
    typedef enum logic [1:0] {IDLE, INIT, SEND, DONE} state_t;
    state_t state, state_n;
    logic [2*NSYM-1:0] wd;
    logic [KW-1:0] k, k_n;
    logic [HW-1:0] h, h_n;
    logic [1:0] sym;
    logic last_h;
    assign load_ready = state == IDLE;
    assign last_h = h == HW'(HOLD - 1);
    always_comb begin
        state_n = state;
        k_n = k;
        h_n = h;
        case (state)
            IDLE: state_n = load_valid ? INIT : IDLE;
            INIT: begin
                state_n = SEND;
                k_n = '0;
                h_n = '0;
            end
            SEND: begin
                h_n = last_h ? '0 : h + 1'b1;
                k_n = last_h ? k + 1'b1 : k;
                state_n = (last_h && k == KW'(NSYM - 1)) ? DONE : SEND;
            end
            DONE: begin
`ifdef MATRICULA_SYM_TX_LOOP_EN
                state_n = INIT;
`else
                state_n = IDLE;
`endif
            end
        endcase
        if (abort)
            state_n = IDLE;
        // symbol k_n of the word, zero-extended to an even number of bits
        sym = 2'(wd >> (2 * (NSYM - 1 - int'(k_n))));
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            wd <= '0;
            k <= '0;
            h <= '0;
            a <= '0;
            a_valid <= 1'b0;
            fsm_res <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= state_n;
            k <= k_n;
            h <= h_n;
            if (abort)
                wd <= '0;
            else if (state == IDLE && load_valid)
                wd <= (2*NSYM)'(load_data);
            a <= state_n == SEND ? sym : 2'b00;
            a_valid <= state_n == SEND;
            fsm_res <= state_n != INIT;
            busy <= state_n != IDLE;
            done <= state_n == DONE;
        end
    end
endmodule

// File: tb/tb_matricula_sym_tx.sv
// tb_matricula_sym_tx: checks two configurations each cycle against a frame-time model, plus directed literal checks.
module tb_matricula_sym_tx;
    localparam int W0 = 17, H0 = 2, N0 = (W0 + 1) / 2;
    localparam int W1 = 4, H1 = 1, N1 = (W1 + 1) / 2;
    logic clk = 0, reset = 1, abort = 0, lv0 = 0, lv1 = 0;
    logic [W0-1:0] ld0 = '0;
    logic [W1-1:0] ld1 = '0;
    logic lr0, av0, fr0, bz0, dn0, lr1, av1, fr1, bz1, dn1;
    logic [1:0] a0, a1;
    int n_cmp = 0, n_bad = 0, bc0 = 0, bc1 = 0, s = 0;
    bit chk_en = 0;
    bit m_act [2] = '{1'b0, 1'b0};
    bit m_r [2] = '{1'b1, 1'b1};
    int m_t [2] = '{0, 0};
    logic [31:0] m_w [2] = '{32'd0, 32'd0};
    int seq0 [9] = '{1, 1, 2, 2, 1, 1, 3, 1, 3};

    always #5 clk = ~clk;

    matricula_sym_tx #(.WIDTH(W0), .HOLD(H0)) u0 (
        .clk(clk), .reset(reset), .load_valid(lv0), .load_ready(lr0), .load_data(ld0),
        .abort(abort), .a(a0), .a_valid(av0), .fsm_res(fr0), .busy(bz0), .done(dn0));
    matricula_sym_tx #(.WIDTH(W1), .HOLD(H1)) u1 (
        .clk(clk), .reset(reset), .load_valid(lv1), .load_ready(lr1), .load_data(ld1),
        .abort(abort), .a(a1), .a_valid(av1), .fsm_res(fr1), .busy(bz1), .done(dn1));

    // frame time t: 0 = reset pulse, 1..N*H = symbols, N*H+1 = done
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_act[i] <= 1'b0;
                m_r[i] <= 1'b1;
            end else begin
                m_r[i] <= 1'b0;
                if (abort)
                    m_act[i] <= 1'b0;
                else if (m_act[i]) begin
                    if (m_t[i] == (i == 1 ? N1 * H1 : N0 * H0) + 1) begin
`ifdef MATRICULA_SYM_TX_LOOP_EN
                        m_t[i] <= 0;
`else
                        m_act[i] <= 1'b0;
`endif
                    end else
                        m_t[i] <= m_t[i] + 1;
                end else if (i == 1 ? lv1 : lv0) begin
                    m_act[i] <= 1'b1;
                    m_t[i] <= 0;
                    m_w[i] <= i == 1 ? 32'(ld1) : 32'(ld0);
                end
            end
        end
    end

    function automatic logic [5:0] expv(int i);
        int n = i == 1 ? N1 : N0;
        int h = i == 1 ? H1 : H0;
        int t = m_t[i];
        logic [1:0] sy;
        if (!m_act[i]) return {2'b00, 1'b0, ~m_r[i], 1'b0, 1'b0};
        if (t == 0) return 6'b000010;
        if (t > n * h) return 6'b000111;
        sy = 2'(m_w[i] >> (2 * (n - 1 - (t - 1) / h)));
        return {sy, 4'b1110};
    endfunction

    function automatic logic [5:0] gotv(int i);
        return i == 1 ? {a1, av1, fr1, bz1, dn1} : {a0, av0, fr0, bz0, dn0};
    endfunction

    task automatic check(string nm, int g, int e);
        n_cmp++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, g, e);
        end
    endtask

    task automatic cmp_cycle(int i);
        logic [5:0] g = gotv(i);
        logic [5:0] e = expv(i);
        check($sformatf("u%0d_a", i), int'(g[5:4]), int'(e[5:4]));
        check($sformatf("u%0d_a_valid", i), int'(g[3]), int'(e[3]));
        check($sformatf("u%0d_fsm_res", i), int'(g[2]), int'(e[2]));
        check($sformatf("u%0d_busy", i), int'(g[1]), int'(e[1]));
        check($sformatf("u%0d_done", i), int'(g[0]), int'(e[0]));
        check($sformatf("u%0d_load_ready", i), int'(i == 1 ? lr1 : lr0), int'(!m_act[i]));
    endtask

    always @(negedge clk)
        if (chk_en)
            for (int i = 0; i < 2; i++) cmp_cycle(i);

    always @(negedge clk) begin
        bc0 <= bc0 + int'(bz0);
        bc1 <= bc1 + int'(bz1);
    end

    // entered on the reset-pulse cycle of a 92535 frame on u0
    task automatic frame0(string tag);
        check({tag, "_init_fsm_res"}, int'(fr0), 0);
        check({tag, "_init_a_valid"}, int'(av0), 0);
        for (int j = 0; j < 18; j++) begin
            @(negedge clk);
            check({tag, "_a"}, int'(a0), seq0[j / 2]);
            check({tag, "_a_valid"}, int'(av0), 1);
        end
        @(negedge clk);
        check({tag, "_done"}, int'(dn0), 1);
        check({tag, "_done_a_valid"}, int'(av0), 0);
    endtask

    initial begin
        @(negedge clk);
        chk_en = 1;
        check("rst_fsm_res", int'(fr0), 0);
        check("rst_busy", int'(bz0), 0);
        check("rst_ready", int'(lr0), 1);
        reset = 0;
        @(negedge clk);
        check("rst_release_fsm_res", int'(fr0), 1);
`ifdef MATRICULA_SYM_TX_LOOP_EN
        ld0 = 17'h16977; lv0 = 1;
        @(negedge clk);
        lv0 = 0;
        for (int p = 0; p < 3; p++) begin
            if (p > 0) @(negedge clk);
            frame0($sformatf("loop%0d", p));
            check("loop_ready", int'(lr0), 0);
        end
        abort = 1;
        @(negedge clk);
        abort = 0;
        check("loop_abort_busy", int'(bz0), 0);
        check("loop_abort_ready", int'(lr0), 1);
`else
        s = bc0; ld0 = 17'h16977; lv0 = 1;
        @(negedge clk);
        lv0 = 0;
        frame0("f1");
        @(negedge clk);
        check("f1_ready", int'(lr0), 1);
        check("f1_busy_cycles", bc0 - s, 20);
        s = bc1; ld1 = 4'b1101; lv1 = 1;
        @(negedge clk);
        lv1 = 0;
        check("even_init_fsm_res", int'(fr1), 0);
        @(negedge clk);
        check("even_a0", int'(a1), 3);
        @(negedge clk);
        check("even_a1", int'(a1), 1);
        @(negedge clk);
        check("even_done", int'(dn1), 1);
        @(negedge clk);
        check("even_ready", int'(lr1), 1);
        check("even_busy_cycles", bc1 - s, 4);
        ld0 = 17'h16977; lv0 = 1;
        @(negedge clk);
        lv0 = 0;
        repeat (7) @(negedge clk);
        check("abort_sym3", int'(a0), 2);
        abort = 1;
        @(negedge clk);
        abort = 0;
        check("abort_busy", int'(bz0), 0);
        check("abort_a", int'(a0), 0);
        check("abort_a_valid", int'(av0), 0);
        check("abort_done", int'(dn0), 0);
        check("abort_ready", int'(lr0), 1);
        ld0 = 17'h1ffff; lv0 = 1; abort = 1;
        @(negedge clk);
        lv0 = 0; abort = 0;
        check("abort_load_busy", int'(bz0), 0);
        @(negedge clk);
        check("abort_load_busy2", int'(bz0), 0);
        ld0 = 17'h16977; lv0 = 1;
        @(negedge clk);
        lv0 = 0;
        repeat (11) @(negedge clk);
        check("rstmid_sym5", int'(a0), 1);
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("rstmid_a", int'(a0), 0);
        check("rstmid_a_valid", int'(av0), 0);
        check("rstmid_fsm_res", int'(fr0), 0);
        check("rstmid_busy", int'(bz0), 0);
        check("rstmid_done", int'(dn0), 0);
        @(negedge clk);
        check("rstmid_release", int'(fr0), 1);
        s = bc0; ld0 = 17'h16977; lv0 = 1;
        @(negedge clk);
        ld0 = 17'h00000;
        frame0("ign");
        @(negedge clk);
        check("ign_ready", int'(lr0), 1);
        check("ign_busy_cycles", bc0 - s, 20);
        @(negedge clk);
        lv0 = 0;
        check("ign_new_busy", int'(bz0), 1);
        check("ign_new_fsm_res", int'(fr0), 0);
        repeat (20) @(negedge clk);
        check("ign_new_idle", int'(bz0), 0);
`endif
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/matricula_sym_tx.md
# matricula_sym_tx

Symbol transmitter that drives the 2-bit input bus of the team's 3-bit sequence-detector FSMs. It accepts a binary word, such as a student ID like 92535, and emits it as 2-bit symbols, most-significant first. Each symbol is held for a programmable number of clock cycles. Before the first symbol it pulses an active-low reset to the downstream FSM, so the FSM starts from state zero. This lets the FSM benches replay an ID sequence deterministically, and lets hardware do the same without hand-written stimulus.

## Interface
- WIDTH, 17, number of bits in the loaded word (≥1); NSYM = (WIDTH+1)/2 symbols.
- HOLD, 2, clock cycles each symbol is held on `a` (≥1).
- clk  input  1  single clock, all logic on rising edge.
- reset  input  1  one clock; reset is synchronous and active-high.
- load_valid  input  1  word offered on load_data.
- load_ready  output  1  block can accept a word; high only in IDLE.
- load_data  input  WIDTH  word to transmit.
- abort  input  1  synchronous stop; returns to IDLE.
- a  output  2  symbol to downstream FSM input.
- a_valid  output  1  `a` carries a live symbol.
- fsm_res  output  1  active-low reset for the downstream FSM.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the last symbol's hold completes.

## Operation
- States are IDLE, INIT, SEND and DONE. The symbol index counter has $clog2(NSYM+1) bits; the hold counter has $clog2(HOLD+1) bits.
- IDLE:
  - a=0, a_valid=0, fsm_res=1, done=0, busy=0, load_ready=1.
  - When load_valid=1 and abort=0, latch load_data and go to INIT.
- INIT lasts 1 cycle:
  - fsm_res=0, a=0, a_valid=0.
  - Then go to SEND with symbol index k=0.
- SEND:
  - a = symbol k, a_valid=1, fsm_res=1.
  - Each symbol is held exactly HOLD cycles.
  - After symbol NSYM-1 completes its hold, go to DONE.
- Symbol mapping:
  - The word is conceptually zero-extended to 2·NSYM bits at the MSB.
  - Symbol k = bits [2·NSYM-1-2k : 2·NSYM-2-2k].
  - When WIDTH is odd, symbol 0 = {1'b0, load_data[WIDTH-1]}.
- DONE lasts 1 cycle:
  - done=1, a=0, a_valid=0.
  - Then go to IDLE.
- abort:
  - In any state, abort=1 at a rising edge forces IDLE on that edge.
  - No done pulse is produced, and the latched word is discarded.
  - If abort and load_valid are asserted together in IDLE, abort wins and the load is ignored.
- load_valid outside IDLE is ignored; load_ready=0 there.
- reset:
  - At any edge, reset forces IDLE and clears the word and both counters.
  - Registered outputs during and immediately after the reset edge: a=0, a_valid=0, done=0, busy=0, fsm_res=0.
  - fsm_res rises to 1 on the first edge where reset=0.
  - Reset in the middle of a frame never produces a done pulse.

## Timing
- a, a_valid, fsm_res, done and busy are registered. load_ready is decoded combinationally from the state.
- Load accepted at edge E:
  - INIT during E..E+1 (fsm_res low for exactly one cycle).
  - Symbol 0 valid from E+1 to E+1+HOLD.
  - done high during the single cycle starting at E+1+NSYM·HOLD.
  - load_ready high again starting at E+2+NSYM·HOLD.
- busy stays high for exactly NSYM·HOLD+2 cycles per frame.
- Symbols change only on hold boundaries. The symbol after k begins exactly HOLD cycles after k began.
- a_valid is low on the INIT cycle, so the downstream FSM sees its reset before the first symbol edge.
- Back-to-back frames: the minimum gap between frames is one IDLE cycle.

## Configuration
- MATRICULA_SYM_TX_LOOP_EN, when defined:
  - DONE sets done=1 and then returns to INIT instead of IDLE.
  - The latched word replays indefinitely, with a fresh fsm_res pulse before each pass.
  - Only abort or reset returns the block to IDLE.
  - load_ready stays low while looping.
- Without the macro: each frame is single-shot, DONE goes to IDLE, and the loop logic is absent.

## Test plan
- Single 92535 frame:
  - Stimulus: WIDTH=17, HOLD=2, load_data=17'h16977, reset then load.
  - Required: fsm_res low for 1 cycle, then `a` = 1,1,2,2,1,1,3,1,3, each for 2 cycles.
  - Required: done 1 cycle later, total busy=20 cycles.
- Even width, HOLD=1:
  - Stimulus: WIDTH=4, load 4'b1101.
  - Required: `a` = 3,1 for one cycle each, done at cycle E+3, busy=4.
- Abort:
  - Stimulus: assert abort during symbol 3 of the 92535 frame.
  - Required: next edge has busy=0, a=0, a_valid=0, no done pulse, load_ready=1.
  - Stimulus: assert load_valid together with abort in IDLE.
  - Required: load ignored.
- Reset mid-frame:
  - Stimulus: reset=1 for one edge during symbol 5.
  - Required: next cycle a=0, a_valid=0, fsm_res=0, busy=0, no done pulse.
  - Required: fsm_res=1 after the first non-reset edge, and a new load starts cleanly.
- Ignored load:
  - Stimulus: load_valid=1 with a different word while busy.
  - Required: the original sequence is unchanged; the new word is accepted only once load_ready=1.
- Loop mode:
  - Stimulus: with MATRICULA_SYM_TX_LOOP_EN defined, load 17'h16977 and run 3 passes.
  - Required: an identical 9-symbol sequence each pass, with an fsm_res pulse and a done pulse between passes.
  - Required: abort exits to IDLE.
